// File: rtl/alu_control_sequencer.sv
// Hardwired fetch/decode/execute sequencer driving every Datapath control input.
// Ports: Clock, Clear (sync high reset), Start, IR (in); Run, bus/load strobes, CONTROL, R_Out, R_In, Illegal (out).
module alu_control_sequencer #(
    parameter int NUM_REGS = 16,
    parameter int OPW      = 5
) (
    input  logic                Clock,
    input  logic                Clear,
    input  logic                Start,
    input  logic [31:0]         IR,
    output logic                Run,
    output logic                PC_Out,
    output logic                ZLO_Out,
    output logic                ZHI_Out,
    output logic                MDR_Out,
    output logic                MAR_In,
    output logic                PC_In,
    output logic                MDR_In,
    output logic                IR_In,
    output logic                Y_In,
    output logic                Z_In,
    output logic                LO_In,
    output logic                HI_In,
    output logic                IncPC,
    output logic                Read,
    output logic [OPW-1:0]      CONTROL,
    output logic [NUM_REGS-1:0] R_Out,
    output logic [NUM_REGS-1:0] R_In,
    output logic                Illegal
);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_t;

    state_t state;
    state_t state_n;

    logic [OPW-1:0]      op;
    logic                is_alu;
    logic                is_md;
    logic                is_nop;
    logic                is_halt;
    logic [NUM_REGS-1:0] ra_sel;
    logic [NUM_REGS-1:0] rb_sel;
    logic [NUM_REGS-1:0] rc_sel;
    logic                unused_ir;

    assign op      = IR[31 -: OPW];
    assign is_alu  = (op <= OPW'(13));
    assign is_md   = (op == OPW'(14)) || (op == OPW'(15));
    assign is_nop  = (op == OPW'(26));
    assign is_halt = (op == OPW'(27));

    // Register fields decode straight to one-hot selects.
    assign ra_sel = NUM_REGS'(1) << IR[26:23];
    assign rb_sel = NUM_REGS'(1) << IR[22:19];
    assign rc_sel = NUM_REGS'(1) << IR[18:15];

    assign unused_ir = ^IR[14:0];

    always_ff @(posedge Clock) begin
        if (Clear) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        Run     = 1'b0;
        PC_Out  = 1'b0;
        ZLO_Out = 1'b0;
        ZHI_Out = 1'b0;
        MDR_Out = 1'b0;
        MAR_In  = 1'b0;
        PC_In   = 1'b0;
        MDR_In  = 1'b0;
        IR_In   = 1'b0;
        Y_In    = 1'b0;
        Z_In    = 1'b0;
        LO_In   = 1'b0;
        HI_In   = 1'b0;
        IncPC   = 1'b0;
        Read    = 1'b0;
        CONTROL = '0;
        R_Out   = '0;
        R_In    = '0;
        Illegal = 1'b0;
        unique case (state)
            S_IDLE: if (Start) state_n = S_T0;
            S_T0: begin
                Run = 1'b1; PC_Out = 1'b1; MAR_In = 1'b1;
                IncPC = 1'b1; Z_In = 1'b1;
                state_n = S_T1;
            end
            S_T1: begin
                Run = 1'b1; ZLO_Out = 1'b1; PC_In = 1'b1;
                Read = 1'b1; MDR_In = 1'b1;
                state_n = S_T2;
            end
            S_T2: begin
                Run = 1'b1; MDR_Out = 1'b1; IR_In = 1'b1;
                state_n = S_T3;
            end
            S_T3: begin
                Run = 1'b1;
                if (is_alu || is_md) begin
                    R_Out = rb_sel; Y_In = 1'b1;
                    state_n = S_T4;
                end else if (is_nop) begin
                    state_n = S_T0;
                end else if (is_halt) begin
                    state_n = S_HALT;
                end else begin
                    // Undefined opcode behaves as nop but is flagged.
                    Illegal = 1'b1;
                    state_n = S_T0;
                end
            end
            S_T4: begin
                Run = 1'b1; R_Out = rc_sel; Z_In = 1'b1;
                CONTROL = op;
                state_n = S_T5;
            end
            S_T5: begin
                Run = 1'b1; ZLO_Out = 1'b1;
                if (is_md) begin
                    LO_In = 1'b1;
                    state_n = S_T6;
                end else begin
                    R_In = ra_sel;
                    state_n = S_T0;
                end
            end
            S_T6: begin
                Run = 1'b1; ZHI_Out = 1'b1; HI_In = 1'b1;
                state_n = S_T0;
            end
            S_HALT: if (Start) state_n = S_T0;
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Self-checking bench for alu_control_sequencer: instruction table plus
// hand-written reset/halt sequences, checked through an expected-output queue.
module tb_alu_control_sequencer;

    typedef struct packed {
        logic        run;
        logic        pc_out;
        logic        zlo_out;
        logic        zhi_out;
        logic        mdr_out;
        logic        mar_in;
        logic        pc_in;
        logic        mdr_in;
        logic        ir_in;
        logic        y_in;
        logic        z_in;
        logic        lo_in;
        logic        hi_in;
        logic        inc_pc;
        logic        read;
        logic        illegal;
        logic [4:0]  control;
        logic [15:0] r_out;
        logic [15:0] r_in;
    } out_t;

    typedef struct {
        logic [31:0] ir;
        int          len;
        logic [15:0] t3_rout;
        logic [15:0] t4_rout;
        logic [4:0]  ctrl;
        logic [15:0] t5_rin;
        bit          ill;
        bit          halt;
        bit          noise;
    } vec_t;

    logic        clk = 1'b0;
    logic        clear;
    logic        start;
    logic [31:0] ir;
    logic        run, pc_out, zlo_out, zhi_out, mdr_out;
    logic        mar_in, pc_in, mdr_in, ir_in, y_in, z_in;
    logic        lo_in, hi_in, inc_pc, read, illegal;
    logic [4:0]  control;
    logic [15:0] r_out, r_in;
    out_t        act;

    int checks = 0;
    int errors = 0;
    out_t sb[$];
    vec_t vt[10];

    always #5 clk = ~clk;

    alu_control_sequencer #(.NUM_REGS(16), .OPW(5)) dut (
        .Clock(clk), .Clear(clear), .Start(start), .IR(ir),
        .Run(run), .PC_Out(pc_out), .ZLO_Out(zlo_out),
        .ZHI_Out(zhi_out), .MDR_Out(mdr_out), .MAR_In(mar_in),
        .PC_In(pc_in), .MDR_In(mdr_in), .IR_In(ir_in),
        .Y_In(y_in), .Z_In(z_in), .LO_In(lo_in), .HI_In(hi_in),
        .IncPC(inc_pc), .Read(read), .CONTROL(control),
        .R_Out(r_out), .R_In(r_in), .Illegal(illegal)
    );

    assign act = {run, pc_out, zlo_out, zhi_out, mdr_out, mar_in,
                  pc_in, mdr_in, ir_in, y_in, z_in, lo_in, hi_in,
                  inc_pc, read, illegal, control, r_out, r_in};

    function automatic out_t e_t0();
        out_t e = '0;
        e.run = 1; e.pc_out = 1; e.mar_in = 1;
        e.inc_pc = 1; e.z_in = 1;
        return e;
    endfunction

    function automatic out_t e_t1();
        out_t e = '0;
        e.run = 1; e.zlo_out = 1; e.pc_in = 1;
        e.read = 1; e.mdr_in = 1;
        return e;
    endfunction

    function automatic out_t e_t2();
        out_t e = '0;
        e.run = 1; e.mdr_out = 1; e.ir_in = 1;
        return e;
    endfunction

    task automatic step(input string tag);
        out_t exp;
        @(posedge clk);
        #1;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, got %h", tag, act);
        end else begin
            exp = sb.pop_front();
            if (act !== exp) begin
                errors++;
                $display("FAIL %s: got %h required %h", tag, act, exp);
            end
        end
    endtask

    // Entered with the DUT sitting in T0; leaves it sitting in T0.
    task automatic exec(input vec_t v, input int n);
        out_t e;
        string tag;
        tag = $sformatf("vec%0d", n);
        ir = 32'h0;
        start = v.noise;
        sb.push_back(e_t1()); step({tag, "_t1"});
        start = 1'b0;
        sb.push_back(e_t2()); step({tag, "_t2"});
        ir = v.ir;
        e = '0; e.run = 1;
        if (v.len >= 6) begin
            e.y_in = 1; e.r_out = v.t3_rout;
        end else begin
            e.illegal = v.ill;
        end
        sb.push_back(e); step({tag, "_t3"});
        if (v.len >= 6) begin
            start = v.noise;
            e = '0; e.run = 1; e.z_in = 1;
            e.r_out = v.t4_rout; e.control = v.ctrl;
            sb.push_back(e); step({tag, "_t4"});
            start = 1'b0;
            e = '0; e.run = 1; e.zlo_out = 1;
            e.lo_in = (v.len == 7); e.r_in = v.t5_rin;
            sb.push_back(e); step({tag, "_t5"});
            if (v.len == 7) begin
                e = '0; e.run = 1; e.zhi_out = 1; e.hi_in = 1;
                sb.push_back(e); step({tag, "_t6"});
            end
        end
        if (v.halt) begin
            for (int i = 0; i < 3; i++) begin
                sb.push_back('0); step({tag, "_halt"});
            end
            start = 1'b1;
        end
        sb.push_back(e_t0()); step({tag, "_next_t0"});
        start = 1'b0;
    endtask

    initial begin
        //        ir            len t3_rout   t4_rout   ctrl    t5_rin   ill halt noise
        vt[0] = '{32'h4A920000, 6, 16'h0004, 16'h0010, 5'd9,  16'h0020, 0, 0, 0};
        vt[1] = '{32'h70918000, 7, 16'h0004, 16'h0008, 5'd14, 16'h0000, 0, 0, 0};
        vt[2] = '{32'hD0000000, 4, 16'h0000, 16'h0000, 5'd0,  16'h0000, 0, 0, 0};
        vt[3] = '{32'hA8000000, 4, 16'h0000, 16'h0000, 5'd0,  16'h0000, 1, 0, 0};
        vt[4] = '{32'hD8000000, 4, 16'h0000, 16'h0000, 5'd0,  16'h0000, 0, 1, 0};
        vt[5] = '{32'h7FFF8000, 7, 16'h8000, 16'h8000, 5'd15, 16'h0000, 0, 0, 0};
        vt[6] = '{32'h00000000, 6, 16'h0001, 16'h0001, 5'd0,  16'h0001, 0, 0, 0};
        vt[7] = '{32'h6F838000, 6, 16'h0001, 16'h0080, 5'd13, 16'h8000, 0, 0, 0};
        vt[8] = '{32'h80000000, 4, 16'h0000, 16'h0000, 5'd0,  16'h0000, 1, 0, 0};
        vt[9] = '{32'h4A920000, 6, 16'h0004, 16'h0010, 5'd9,  16'h0020, 0, 0, 1};

        clear = 1'b1;
        start = 1'b1;
        ir = 32'h0;
        sb.push_back('0); step("reset0");
        sb.push_back('0); step("reset1");
        clear = 1'b0;
        sb.push_back(e_t0()); step("first_t0");
        start = 1'b0;

        for (int i = 0; i < 10; i++) exec(vt[i], i);

        // Undefined opcode 11111 at the top of the encoding space.
        vt[8].ir = 32'hF8000000;
        exec(vt[8], 10);

        // Clear during T4 of an add: back to IDLE, nothing committed.
        ir = 32'h0;
        sb.push_back(e_t1()); step("rst_t1");
        sb.push_back(e_t2()); step("rst_t2");
        ir = 32'h4A920000;
        begin
            out_t e;
            e = '0; e.run = 1; e.y_in = 1; e.r_out = 16'h0004;
            sb.push_back(e); step("rst_t3");
            e = '0; e.run = 1; e.z_in = 1;
            e.r_out = 16'h0010; e.control = 5'd9;
            sb.push_back(e); step("rst_t4");
        end
        clear = 1'b1;
        start = 1'b1;
        sb.push_back('0); step("rst_idle");
        clear = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sb.push_back('0); step("rst_wait");
        end
        start = 1'b1;
        sb.push_back(e_t0()); step("rst_restart");
        start = 1'b0;
        exec(vt[0], 11);

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL leftover: got %0d entries required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
